// File: rtl/imm_encoder_if.sv
// imm_encoder_if -- request/response bundle for imm_encoder.
//
// Request side : in_valid, in_ready, immsrc, imm, opcode, funct3, rd, rs1, rs2
// Response side: out_valid, out_ready, instr
// Status       : err (one-cycle reject pulse), err_count (saturating), enc_count (wrapping)
//
// Modports:
//   master -- the request producer and response consumer (drives requests, out_ready)
//   slave  -- the encoder itself
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  immsrc;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] enc_count;

  modport master (
    output in_valid, immsrc, imm, opcode, funct3, rd, rs1, rs2, out_ready,
    input  in_ready, out_valid, instr, err, err_count, enc_count
  );

  modport slave (
    input  in_valid, immsrc, imm, opcode, funct3, rd, rs1, rs2, out_ready,
    output in_ready, out_valid, instr, err, err_count, enc_count
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder -- packs RV32 instruction fields plus a decoded immediate back into a
// 32-bit instruction word (inverse of immediate decode) and queues the result.
//
// Ports:
//   clk  -- clock, rising edge
//   rst  -- asynchronous active-high reset; empties the queue and clears counters
//   bus  -- imm_encoder_if.slave: request handshake, output queue head, status
//
// Parameters:
//   FIFO_DEPTH -- output queue depth in entries (power of two, >= 2)
//
// Build option:
//   IMM_ENCODER_RANGE_CHECK_EN -- when defined, accepted requests whose immediate does not
//   fit the selected format are rejected like an invalid immsrc. When undefined, unused
//   immediate bits are dropped and only invalid immsrc values are rejected.
module imm_encoder #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  imm_encoder_if.slave bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic [7:0]      err_count_q;
  logic [15:0]     enc_count_q;

  logic [31:0] enc;
  logic        fmt_ok;
  logic        range_ok;
  logic        accept;
  logic        push;
  logic        pop;

  // Field packing per format; invalid formats flag fmt_ok low.
  always_comb begin
    enc    = '0;
    fmt_ok = 1'b1;
    case (bus.immsrc)
      3'b000: enc = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'b001: enc = {bus.imm[31:12], bus.rd, bus.opcode};
      3'b010: enc = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
      3'b011: enc = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                     bus.imm[4:1], bus.imm[11], bus.opcode};
      3'b100: enc = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                     bus.rd, bus.opcode};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef IMM_ENCODER_RANGE_CHECK_EN
  // Immediate must be representable: sign bits above the field all equal, and
  // branch/jump offsets must be even. U-type must have a zero low 12 bits.
  always_comb begin
    range_ok = 1'b1;
    case (bus.immsrc)
      3'b000, 3'b010: range_ok = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
      3'b001:         range_ok = ~(|bus.imm[11:0]);
      3'b011:         range_ok = ((&bus.imm[31:12]) | ~(|bus.imm[31:12])) & ~bus.imm[0];
      3'b100:         range_ok = ((&bus.imm[31:20]) | ~(|bus.imm[31:20])) & ~bus.imm[0];
      default:        range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  // in_ready depends only on occupancy, so a full queue refuses a push even while popping.
  assign bus.in_ready  = (cnt_q < CntW'(FIFO_DEPTH));
  assign bus.out_valid = (cnt_q != '0);
  assign bus.instr     = mem_q[rd_ptr_q];
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;
  assign bus.enc_count = enc_count_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & fmt_ok & range_ok;
  assign pop    = bus.out_valid & bus.out_ready;

  // Storage needs no reset: only entries counted by cnt_q are ever presented.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= enc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      enc_count_q <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      err_q <= accept & ~(fmt_ok & range_ok);
      if (accept && !(fmt_ok && range_ok) && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 1'b1;
      end
      if (pop) enc_count_q <= enc_count_q + 1'b1;
    end
  end

endmodule
